// File: rtl/pwm_prescaler_rep.sv
// pwm_prescaler_rep: PWM prescaler with repetition counter and update-event generation.
//   Divides clk_psc_i by (psc_eff+1) into a one-cycle ck_cnt_o enable and issues uev_o
//   after (rcr+1) prescaler wraps. Preloads are buffered in shadows (pspe_i=1) or the
//   prescaler preload is used directly (pspe_i=0).
// Ports:
//   clk_psc_i      prescaler clock
//   rst_n_i        asynchronous active-low reset
//   cen_i          counter enable
//   psc_preload_i  prescaler preload (division = value+1)
//   rcr_preload_i  repetition preload (update every value+1 wraps)
//   pspe_i         preload buffering enable
//   ug_i           software update generation pulse
//   udis_i         update disable
//   uif_clr_i      clear sticky update flag
//   ck_cnt_o       counter clock-enable pulse
//   uev_o          update event pulse
//   uif_o          sticky update flag
//   psc_cnt_o      prescaler count value
//   rep_cnt_o      remaining repetitions
module pwm_prescaler_rep #(
    parameter int PSC_W = 16,
    parameter int REP_W = 8
) (
    input  logic             clk_psc_i,
    input  logic             rst_n_i,
    input  logic             cen_i,
    input  logic [PSC_W-1:0] psc_preload_i,
    input  logic [REP_W-1:0] rcr_preload_i,
    input  logic             pspe_i,
    input  logic             ug_i,
    input  logic             udis_i,
    input  logic             uif_clr_i,
    output logic             ck_cnt_o,
    output logic             uev_o,
    output logic             uif_o,
    output logic [PSC_W-1:0] psc_cnt_o,
    output logic [REP_W-1:0] rep_cnt_o
);
    logic [PSC_W-1:0] psc_cnt, psc_shadow, psc_eff, psc_cnt_nxt, psc_shadow_nxt;
    logic [REP_W-1:0] rep_cnt, rcr_shadow, rep_cnt_nxt, rcr_shadow_nxt;
    logic             ck_nxt, uev_nxt, uif_nxt, wrap, load;

    // Defaults cover ug_i and the disabled case: prescaler cleared, repetition
    // counter re-armed from its shadow, no pulses.
    always_comb begin
        psc_eff     = pspe_i ? psc_shadow : psc_preload_i;
        wrap        = psc_cnt >= psc_eff;
        psc_cnt_nxt = '0;
        rep_cnt_nxt = rcr_shadow;
        ck_nxt      = 1'b0;
        load        = 1'b0;
        if (ug_i)
            load = !udis_i;
        else if (cen_i) begin
            if (!wrap) begin
                psc_cnt_nxt = psc_cnt + 1'b1;
                rep_cnt_nxt = rep_cnt;
            end else begin
                ck_nxt = 1'b1;
                if (rep_cnt != '0)
                    rep_cnt_nxt = rep_cnt - 1'b1;
                else
                    load = !udis_i;
            end
        end
        // An update (software or repetition underflow) reloads everything from the preloads.
        if (load)
            rep_cnt_nxt = rcr_preload_i;
        psc_shadow_nxt = load ? psc_preload_i : psc_shadow;
        rcr_shadow_nxt = load ? rcr_preload_i : rcr_shadow;
        uev_nxt        = load;
        uif_nxt        = uev_nxt | (uif_o & !uif_clr_i);
    end

    always_ff @(posedge clk_psc_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            psc_cnt    <= '0;
            rep_cnt    <= '0;
            psc_shadow <= '0;
            rcr_shadow <= '0;
            ck_cnt_o   <= 1'b0;
            uev_o      <= 1'b0;
            uif_o      <= 1'b0;
        end else begin
            psc_cnt    <= psc_cnt_nxt;
            rep_cnt    <= rep_cnt_nxt;
            psc_shadow <= psc_shadow_nxt;
            rcr_shadow <= rcr_shadow_nxt;
            ck_cnt_o   <= ck_nxt;
            uev_o      <= uev_nxt;
            uif_o      <= uif_nxt;
        end
    end

    assign psc_cnt_o = psc_cnt;
    assign rep_cnt_o = rep_cnt;
endmodule

// File: tb/tb_pwm_prescaler_rep.sv
// tb_pwm_prescaler_rep: directed self-checking bench for pwm_prescaler_rep.
module tb_pwm_prescaler_rep;
    logic        clk_psc_i = 1'b0;
    logic        rst_n_i;
    logic        cen_i, pspe_i, ug_i, udis_i, uif_clr_i;
    logic [15:0] psc_preload_i;
    logic [7:0]  rcr_preload_i;
    logic        ck_cnt_o, uev_o, uif_o;
    logic [15:0] psc_cnt_o;
    logic [7:0]  rep_cnt_o;
    int          n_chk = 0;
    int          n_fail = 0;

    pwm_prescaler_rep dut (
        .clk_psc_i    (clk_psc_i),
        .rst_n_i      (rst_n_i),
        .cen_i        (cen_i),
        .psc_preload_i(psc_preload_i),
        .rcr_preload_i(rcr_preload_i),
        .pspe_i       (pspe_i),
        .ug_i         (ug_i),
        .udis_i       (udis_i),
        .uif_clr_i    (uif_clr_i),
        .ck_cnt_o     (ck_cnt_o),
        .uev_o        (uev_o),
        .uif_o        (uif_o),
        .psc_cnt_o    (psc_cnt_o),
        .rep_cnt_o    (rep_cnt_o)
    );

    always #5 clk_psc_i = ~clk_psc_i;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_psc_i);
        #1;
    endtask

    task automatic ug_pulse();
        ug_i = 1'b1;
        tick();
        ug_i = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_ck"}, 32'(ck_cnt_o), 0);
        check({tag, "_uev"}, 32'(uev_o), 0);
        check({tag, "_uif"}, 32'(uif_o), 0);
        check({tag, "_psc"}, 32'(psc_cnt_o), 0);
        check({tag, "_rep"}, 32'(rep_cnt_o), 0);
    endtask

    initial begin
        rst_n_i = 1'b0;
        cen_i = 0; pspe_i = 0; ug_i = 0; udis_i = 0; uif_clr_i = 0;
        psc_preload_i = 0; rcr_preload_i = 0;
        #1;
        check_idle("reset");
        #20 rst_n_i = 1'b1;
        tick();

        // T1: divide by 3, update on every wrap
        pspe_i = 1; psc_preload_i = 2; rcr_preload_i = 0;
        ug_pulse();
        check("t1_ug_uev", 32'(uev_o), 1);
        check("t1_ug_uif", 32'(uif_o), 1);
        check("t1_ug_psc", 32'(psc_cnt_o), 0);
        cen_i = 1;
        for (int i = 1; i <= 9; i++) begin
            tick();
            check("t1_ck", 32'(ck_cnt_o), (i % 3 == 0) ? 1 : 0);
            check("t1_uev", 32'(uev_o), (i % 3 == 0) ? 1 : 0);
            check("t1_psc", 32'(psc_cnt_o), i % 3);
        end
        check("t1_uif", 32'(uif_o), 1);

        // T2: divide by 2, update every 3rd wrap
        psc_preload_i = 1; rcr_preload_i = 2;
        ug_pulse();
        check("t2_ug_rep", 32'(rep_cnt_o), 2);
        for (int i = 1; i <= 12; i++) begin
            tick();
            check("t2_ck", 32'(ck_cnt_o), (i % 2 == 0) ? 1 : 0);
            check("t2_uev", 32'(uev_o), (i % 6 == 0) ? 1 : 0);
            check("t2_rep", 32'(rep_cnt_o), 2 - (i % 6) / 2);
        end

        // T3a: buffered preload change takes effect only after the next update
        psc_preload_i = 4; rcr_preload_i = 0;
        ug_pulse();
        tick(); tick();
        check("t3a_psc2", 32'(psc_cnt_o), 2);
        psc_preload_i = 1;
        tick(); tick();
        check("t3a_psc4", 32'(psc_cnt_o), 4);
        check("t3a_ck4", 32'(ck_cnt_o), 0);
        tick();
        check("t3a_ck5", 32'(ck_cnt_o), 1);
        check("t3a_uev5", 32'(uev_o), 1);
        tick();
        check("t3a_ck6", 32'(ck_cnt_o), 0);
        check("t3a_psc6", 32'(psc_cnt_o), 1);
        tick();
        check("t3a_ck7", 32'(ck_cnt_o), 1);
        check("t3a_uev7", 32'(uev_o), 1);

        // T3b: direct preload lowered below the count wraps on the next clock
        psc_preload_i = 4;
        ug_pulse();
        pspe_i = 0;
        tick(); tick(); tick();
        check("t3b_psc3", 32'(psc_cnt_o), 3);
        psc_preload_i = 1;
        tick();
        check("t3b_ck_wrap", 32'(ck_cnt_o), 1);
        check("t3b_psc_wrap", 32'(psc_cnt_o), 0);
        tick();
        check("t3b_ck_a", 32'(ck_cnt_o), 0);
        tick();
        check("t3b_ck_b", 32'(ck_cnt_o), 1);

        // T4: divide by 1, update every 4th clock
        pspe_i = 1; psc_preload_i = 0; rcr_preload_i = 3;
        ug_pulse();
        for (int i = 1; i <= 8; i++) begin
            tick();
            check("t4_ck", 32'(ck_cnt_o), 1);
            check("t4_uev", 32'(uev_o), (i % 4 == 0) ? 1 : 0);
        end

        // T5: update disabled; shadows (psc 0, rcr 3) must hold
        udis_i = 1; psc_preload_i = 5; rcr_preload_i = 7;
        ug_pulse();
        check("t5_psc", 32'(psc_cnt_o), 0);
        check("t5_uev", 32'(uev_o), 0);
        check("t5_uif_hold", 32'(uif_o), 1);
        check("t5_rep_shadow", 32'(rep_cnt_o), 3);
        uif_clr_i = 1;
        tick();
        uif_clr_i = 0;
        check("t5_ck_shadow", 32'(ck_cnt_o), 1);
        check("t5_rep2", 32'(rep_cnt_o), 2);
        check("t5_uif_clr", 32'(uif_o), 0);
        udis_i = 0;
        tick();
        check("t5_rep1", 32'(rep_cnt_o), 1);
        tick();
        check("t5_rep0", 32'(rep_cnt_o), 0);
        uif_clr_i = 1;
        tick();
        check("t5_uev_set", 32'(uev_o), 1);
        check("t5_uif_setwins", 32'(uif_o), 1);
        check("t5_rep_reload", 32'(rep_cnt_o), 7);
        tick();
        uif_clr_i = 0;
        check("t5_uif_cleared", 32'(uif_o), 0);
        check("t5_uev_low", 32'(uev_o), 0);

        // T6: asynchronous reset mid-count
        psc_preload_i = 4; rcr_preload_i = 2;
        ug_pulse();
        for (int i = 0; i < 8; i++) tick();
        check("t6_psc3", 32'(psc_cnt_o), 3);
        check("t6_rep1", 32'(rep_cnt_o), 1);
        #3 rst_n_i = 1'b0;
        #1;
        check_idle("t6_async");
        #2 rst_n_i = 1'b1;
        // cen dropped mid-count
        ug_pulse();
        for (int i = 0; i < 7; i++) tick();
        check("t6_psc2", 32'(psc_cnt_o), 2);
        check("t6_rep_mid", 32'(rep_cnt_o), 1);
        cen_i = 0;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("t6_off_psc", 32'(psc_cnt_o), 0);
            check("t6_off_rep", 32'(rep_cnt_o), 2);
            check("t6_off_ck", 32'(ck_cnt_o), 0);
            check("t6_off_uev", 32'(uev_o), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
